// File: rtl/scan_anode_driver.sv
`default_nettype none
// ============================================================================
// Module   : scan_anode_driver
// Brief    : Time-multiplexed anode scanner for N-digit seven-segment displays
//            with slot prescaler, digit skip mask, blank time and polarity.
// Revision : 1.0  initial release
// ============================================================================
module scan_anode_driver #(
  parameter int NUM_DIGITS    = 4,
  parameter int DIV           = 100000,
  parameter int BLANK_CYCLES  = 1000,
  parameter bit AN_ACTIVE_LOW = 1'b1,
  localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                  clk,
  input  logic                  clr_n,
  input  logic                  en,
  input  logic [NUM_DIGITS-1:0] digit_mask,
  output logic [NUM_DIGITS-1:0] an,
  output logic [DW-1:0]         dspl,
  output logic                  blank,
  output logic                  slot_tick
);

  localparam int CW        = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int ON_CYCLES = DIV - BLANK_CYCLES;

  localparam logic [CW-1:0]         c_BLANK_LAST = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [CW-1:0]         c_ON_LAST    = CW'(ON_CYCLES - 1);
  localparam logic [NUM_DIGITS-1:0] c_AN_OFF     = {NUM_DIGITS{AN_ACTIVE_LOW}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BLANK = 2'd1,
    S_ON    = 2'd2
  } state_t;

  state_t                r_state;
  logic [CW-1:0]         r_cnt;
  logic [DW-1:0]         r_dspl;
  logic [NUM_DIGITS-1:0] r_an;
  logic                  r_blank;
  logic                  r_tick;

  state_t                w_state_nxt;
  logic [CW-1:0]         w_cnt_nxt;
  logic [DW-1:0]         w_dspl_nxt;
  logic [NUM_DIGITS-1:0] w_an_nxt;
  logic                  w_blank_nxt;
  logic                  w_tick_nxt;

  // First enabled digit index at or after 'start', wrapping; digit d maps to mask bit N-1-d.
  function automatic logic [DW-1:0] f_next(input logic [NUM_DIGITS-1:0] mask, input int start);
    logic [DW-1:0]         sel;
    logic                  found;
    logic [NUM_DIGITS-1:0] shifted;
    int                    idx;
    sel   = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      idx = start + k;
      if (idx >= NUM_DIGITS) idx = idx - NUM_DIGITS;
      shifted = mask >> (NUM_DIGITS - 1 - idx);
      if (!found && shifted[0]) begin
        sel   = DW'(idx);
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  function automatic logic [NUM_DIGITS-1:0] f_an(input logic [DW-1:0] d);
    logic [NUM_DIGITS-1:0] oh;
    oh = NUM_DIGITS'(1) << (NUM_DIGITS - 1 - int'(d));
    return AN_ACTIVE_LOW ? ~oh : oh;
  endfunction

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_dspl_nxt  = r_dspl;
    w_tick_nxt  = 1'b0;

    if (!en) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
      w_dspl_nxt  = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_cnt_nxt  = '0;
          w_dspl_nxt = '0;
          if (digit_mask != '0) begin
            w_dspl_nxt  = f_next(digit_mask, 0);
            w_tick_nxt  = 1'b1;
            w_state_nxt = (BLANK_CYCLES == 0) ? S_ON : S_BLANK;
          end
        end
        S_BLANK: begin
          if (r_cnt == c_BLANK_LAST) begin
            w_cnt_nxt   = '0;
            w_state_nxt = S_ON;
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
        S_ON: begin
          if (r_cnt == c_ON_LAST) begin
            w_cnt_nxt = '0;
            // The mask only matters here and at IDLE exit; mid-slot edits wait for the advance.
            if (digit_mask == '0) begin
              w_state_nxt = S_IDLE;
              w_dspl_nxt  = '0;
            end else begin
              w_dspl_nxt  = f_next(digit_mask, int'(r_dspl) + 1);
              w_tick_nxt  = 1'b1;
              w_state_nxt = (BLANK_CYCLES == 0) ? S_ON : S_BLANK;
            end
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
          w_dspl_nxt  = '0;
        end
      endcase
    end

    w_an_nxt    = (w_state_nxt == S_ON) ? f_an(w_dspl_nxt) : c_AN_OFF;
    w_blank_nxt = (w_state_nxt != S_ON);
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_dspl  <= '0;
      r_an    <= c_AN_OFF;
      r_blank <= 1'b1;
      r_tick  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_dspl  <= w_dspl_nxt;
      r_an    <= w_an_nxt;
      r_blank <= w_blank_nxt;
      r_tick  <= w_tick_nxt;
    end
  end

  assign an        = r_an;
  assign dspl      = r_dspl;
  assign blank     = r_blank;
  assign slot_tick = r_tick;

endmodule
`default_nettype wire

// File: tb/tb_scan_anode_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_scan_anode_driver
// Brief    : Two scanner configurations checked against a slot-position model.
// Revision : 1.0  initial release
// ============================================================================
module tb_scan_anode_driver;

  logic       clk = 1'b0;
  logic       clr_n;
  logic       en_a, en_b;
  logic [3:0] mask_a;
  logic [7:0] mask_b;
  logic [3:0] an_a;
  logic [1:0] dspl_a;
  logic       blank_a, tick_a;
  logic [7:0] an_b;
  logic [2:0] dspl_b;
  logic       blank_b, tick_b;

  always #5 clk = ~clk;

  scan_anode_driver #(.NUM_DIGITS(4), .DIV(8), .BLANK_CYCLES(2), .AN_ACTIVE_LOW(1'b1)) u_a (
    .clk(clk), .clr_n(clr_n), .en(en_a), .digit_mask(mask_a),
    .an(an_a), .dspl(dspl_a), .blank(blank_a), .slot_tick(tick_a)
  );

  scan_anode_driver #(.NUM_DIGITS(8), .DIV(5), .BLANK_CYCLES(0), .AN_ACTIVE_LOW(1'b0)) u_b (
    .clk(clk), .clr_n(clr_n), .en(en_b), .digit_mask(mask_b),
    .an(an_b), .dspl(dspl_b), .blank(blank_b), .slot_tick(tick_b)
  );

  int total = 0;
  int bad   = 0;

  // Model: whether scanning, current digit, cycles elapsed in the slot, tick flag.
  int m_act[2], m_dig[2], m_pos[2], m_tick[2];

  function automatic int p_n(input int i);   return (i == 0) ? 4 : 8; endfunction
  function automatic int p_div(input int i); return (i == 0) ? 8 : 5; endfunction
  function automatic int p_bl(input int i);  return (i == 0) ? 2 : 0; endfunction
  function automatic int p_al(input int i);  return (i == 0) ? 1 : 0; endfunction
  function automatic int in_en(input int i);   return (i == 0) ? int'(en_a) : int'(en_b); endfunction
  function automatic int in_mask(input int i); return (i == 0) ? int'(mask_a) : int'(mask_b); endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int next_en(input int i, input int start);
    int n, m, d;
    n = p_n(i);
    m = in_mask(i);
    for (int k = 0; k < n; k++) begin
      d = (start + k) % n;
      if (((m >> (n - 1 - d)) & 1) != 0) return d;
    end
    return 0;
  endfunction

  function automatic int on_now(input int i);
    return (m_act[i] != 0 && m_pos[i] >= p_bl(i)) ? 1 : 0;
  endfunction

  function automatic int exp_an(input int i);
    int full, oh;
    full = (1 << p_n(i)) - 1;
    if (on_now(i) != 0) begin
      oh = 1 << (p_n(i) - 1 - m_dig[i]);
      return (p_al(i) != 0) ? (full & ~oh) : oh;
    end
    return (p_al(i) != 0) ? full : 0;
  endfunction

  task automatic model_step(input int i);
    m_tick[i] = 0;
    if (!clr_n || in_en(i) == 0) begin
      m_act[i] = 0; m_dig[i] = 0; m_pos[i] = 0;
    end else if (m_act[i] == 0) begin
      if (in_mask(i) != 0) begin
        m_act[i] = 1; m_dig[i] = next_en(i, 0); m_pos[i] = 0; m_tick[i] = 1;
      end
    end else if (m_pos[i] == p_div(i) - 1) begin
      if (in_mask(i) == 0) begin
        m_act[i] = 0; m_dig[i] = 0; m_pos[i] = 0;
      end else begin
        m_dig[i] = next_en(i, m_dig[i] + 1); m_pos[i] = 0; m_tick[i] = 1;
      end
    end else begin
      m_pos[i] = m_pos[i] + 1;
    end
  endtask

  task automatic check_all();
    chk("a_an",    32'(an_a),    exp_an(0));
    chk("a_dspl",  32'(dspl_a),  m_dig[0]);
    chk("a_blank", 32'(blank_a), 1 - on_now(0));
    chk("a_tick",  32'(tick_a),  m_tick[0]);
    chk("b_an",    32'(an_b),    exp_an(1));
    chk("b_dspl",  32'(dspl_b),  m_dig[1]);
    chk("b_blank", 32'(blank_b), 1 - on_now(1));
    chk("b_tick",  32'(tick_b),  m_tick[1]);
  endtask

  task automatic step();
    @(posedge clk);
    model_step(0);
    model_step(1);
    @(negedge clk);
    check_all();
  endtask

  task automatic wait_a_on(input string tag, input int want_dig);
    int ok;
    ok = 0;
    for (int c = 0; c < 40 && ok == 0; c++) begin
      step();
      if (on_now(0) != 0 && (want_dig < 0 || m_dig[0] == want_dig)) ok = 1;
    end
    if (ok == 0) chk(tag, 0, 1);
  endtask

  task automatic wait_a_tick(input string tag);
    int ok;
    ok = 0;
    for (int c = 0; c < 40 && ok == 0; c++) begin
      step();
      if (tick_a === 1'b1) ok = 1;
    end
    if (ok == 0) chk(tag, 0, 1);
  endtask

  initial begin
    int ticks;
    clr_n = 1'b0; en_a = 1'b0; en_b = 1'b0; mask_a = '0; mask_b = '0;
    for (int i = 0; i < 2; i++) begin
      m_act[i] = 0; m_dig[i] = 0; m_pos[i] = 0; m_tick[i] = 0;
    end

    repeat (3) step();
    chk("rst_an_a",    32'(an_a),    32'hF);
    chk("rst_dspl_a",  32'(dspl_a),  0);
    chk("rst_blank_a", 32'(blank_a), 1);
    chk("rst_tick_a",  32'(tick_a),  0);
    chk("rst_an_b",    32'(an_b),    0);
    clr_n = 1'b1;
    step();

    // Full scan on both configurations
    en_a = 1'b1; mask_a = 4'hF; en_b = 1'b1; mask_b = 8'hFF;
    ticks = 0;
    for (int c = 0; c < 32; c++) begin
      step();
      if (c == 0) begin
        chk("scan_tick0", 32'(tick_a), 1);
        chk("scan_dspl0", 32'(dspl_a), 0);
        chk("scan_blank0", 32'(blank_a), 1);
        chk("b_first_an", 32'(an_b), 32'h80);
      end
      if (c == 2)  chk("scan_an_d0", 32'(an_a), 32'h7);
      if (c == 5)  chk("b_an_d1",    32'(an_b), 32'h40);
      if (c == 10) chk("scan_an_d1", 32'(an_a), 32'hB);
      if (c == 26) chk("scan_an_d3", 32'(an_a), 32'hE);
      ticks += int'(tick_a);
    end
    chk("scan_ticks32", ticks, 4);

    // Skip dark digits, then change mask mid-slot
    mask_a = 4'b1010;
    repeat (24) step();
    wait_a_on("wait_on_d0", 0);
    mask_a = 4'b0001;
    wait_a_tick("wait_tick_mask");
    chk("mask_chg_dspl", 32'(dspl_a), 3);
    repeat (2) step();
    chk("mask_chg_an", 32'(an_a), 32'hE);

    // Mask cleared during ON: slot completes, then idle
    wait_a_on("wait_on_stop", -1);
    mask_a = 4'b0000;
    repeat (12) step();
    chk("stop_an", 32'(an_a), 32'hF);
    chk("stop_blank", 32'(blank_a), 1);

    // en dropped mid-blank, then re-asserted
    mask_a = 4'hF;
    wait_a_tick("wait_tick_en");
    en_a = 1'b0;
    step();
    chk("endrop_an", 32'(an_a), 32'hF);
    chk("endrop_blank", 32'(blank_a), 1);
    repeat (3) step();
    en_a = 1'b1;
    step();
    chk("restart_tick", 32'(tick_a), 1);
    chk("restart_dspl", 32'(dspl_a), 0);

    // Single enabled digit
    mask_a = 4'b0100;
    ticks = 0;
    repeat (8) step();
    for (int c = 0; c < 32; c++) begin
      step();
      ticks += int'(tick_a);
    end
    chk("single_ticks32", ticks, 4);
    chk("single_dspl", 32'(dspl_a), 1);

    // Randomized traffic
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 29) == 0) mask_a = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom);
      if ($urandom_range(0, 29) == 0) mask_b = ($urandom_range(0, 7) == 0) ? 8'h0 : 8'($urandom);
      if ($urandom_range(0, 79) == 0) en_a = 1'b0;
      else if (!en_a && $urandom_range(0, 3) == 0) en_a = 1'b1;
      if ($urandom_range(0, 79) == 0) en_b = 1'b0;
      else if (!en_b && $urandom_range(0, 3) == 0) en_b = 1'b1;
      step();
    end

    // Asynchronous reset in the middle of an ON slot
    en_a = 1'b1; en_b = 1'b1; mask_a = 4'hF; mask_b = 8'hFF;
    wait_a_on("wait_on_arst", -1);
    @(posedge clk);
    model_step(0);
    model_step(1);
    #2 clr_n = 1'b0;
    model_step(0);
    model_step(1);
    #1;
    chk("arst_an_a",    32'(an_a),    32'hF);
    chk("arst_dspl_a",  32'(dspl_a),  0);
    chk("arst_blank_a", 32'(blank_a), 1);
    chk("arst_tick_a",  32'(tick_a),  0);
    check_all();
    repeat (2) step();
    clr_n = 1'b1;
    repeat (20) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
